// File: rtl/fc_layer_sequencer.sv
// Address/control sequencer for up to four back-to-back dense layers sharing one MAC.
// Optional macro FC_SEQ_RELU_EN: flag ReLU on every write except the final layer's.
module fc_layer_sequencer #(
  parameter int NUM_LAYERS = 3,
  parameter int LEN0       = 256,
  parameter int LEN1       = 120,
  parameter int LEN2       = 84,
  parameter int LEN3       = 10,
  parameter int LEN4       = 0,
  parameter int COUNT_WID  = 10,
  parameter int ADDR_W     = 16,
  parameter int PIPE_LAT   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 stall_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [1:0]           layer_o,
  output logic                 bias_re_o,
  output logic [ADDR_W-1:0]    bias_addr_o,
  output logic                 weight_re_o,
  output logic [ADDR_W-1:0]    weight_addr_o,
  output logic                 in_re_o,
  output logic [COUNT_WID-1:0] in_addr_o,
  output logic                 in_ext_o,
  output logic                 rd_bank_o,
  output logic                 wr_bank_o,
  output logic                 acc_clr_o,
  output logic                 mac_en_o,
  output logic                 out_we_o,
  output logic [COUNT_WID-1:0] out_addr_o,
  output logic                 relu_en_o
);

  localparam int                   DW     = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT);
  localparam logic [1:0]           LAST_L = 2'(NUM_LAYERS - 1);
  localparam logic [COUNT_WID-1:0] C_ONE  = COUNT_WID'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_BIAS, S_MAC, S_DRAIN, S_WRITE, S_NEXT, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           layer_q, layer_d;
  logic [COUNT_WID-1:0] row_q, row_d, col_q, col_d;
  logic [ADDR_W-1:0]    wptr_q, wptr_d, bbase_q, bbase_d;
  logic [DW-1:0]        drain_q, drain_d;

  // Registered outputs
  logic                 busy_q, busy_d, done_q, done_d;
  logic [1:0]           lyr_q, lyr_d;
  logic                 bias_re_q, bias_re_d, wre_q, wre_d, in_re_q, in_re_d;
  logic [ADDR_W-1:0]    baddr_q, baddr_d, waddr_q, waddr_d;
  logic [COUNT_WID-1:0] iaddr_q, iaddr_d, oaddr_q, oaddr_d;
  logic                 ext_q, ext_d, rdb_q, rdb_d, wrb_q, wrb_d;
  logic                 mac_en_q, mac_en_d, we_q, we_d, relu_q, relu_d;

  logic [COUNT_WID-1:0] in_len, out_len;
  logic                 mac_act;

  function automatic logic [COUNT_WID-1:0] len_of(input logic [2:0] k);
    case (k)
      3'd0:    len_of = COUNT_WID'(LEN0);
      3'd1:    len_of = COUNT_WID'(LEN1);
      3'd2:    len_of = COUNT_WID'(LEN2);
      3'd3:    len_of = COUNT_WID'(LEN3);
      default: len_of = COUNT_WID'(LEN4);
    endcase
  endfunction

  assign in_len  = len_of({1'b0, layer_q});
  assign out_len = len_of({1'b0, layer_q} + 3'd1);
  assign mac_act = (state_q == S_MAC) && !stall_i;

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    row_d   = row_q;
    col_d   = col_q;
    wptr_d  = wptr_q;
    bbase_d = bbase_q;
    drain_d = drain_q;
    unique case (state_q)
      S_IDLE: begin
        layer_d = '0;
        row_d   = '0;
        col_d   = '0;
        wptr_d  = '0;
        bbase_d = '0;
        drain_d = '0;
        if (start_i) state_d = S_BIAS;
      end
      S_BIAS: begin
        drain_d = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        if (!stall_i) begin
          col_d  = col_q + C_ONE;
          wptr_d = wptr_q + ADDR_W'(1);
          if (col_q == in_len - C_ONE) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + DW'(1);
        if (drain_q == DW'(PIPE_LAT - 1)) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (row_q == out_len - C_ONE) begin
          state_d = S_NEXT;
        end else begin
          row_d   = row_q + C_ONE;
          col_d   = '0;
          state_d = S_BIAS;
        end
      end
      S_NEXT: begin
        row_d = '0;
        col_d = '0;
        if (layer_q == LAST_L) begin
          state_d = S_DONE;
        end else begin
          // Bias ROM is packed layer after layer; advance past this layer's rows
          layer_d = layer_q + 2'd1;
          bbase_d = bbase_q + ADDR_W'(out_len);
          state_d = S_BIAS;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are the registered image of the current state/counters
  always_comb begin
    busy_d    = (state_q != S_IDLE);
    done_d    = (state_q == S_DONE);
    lyr_d     = busy_d ? layer_q : 2'd0;
    bias_re_d = (state_q == S_BIAS);
    baddr_d   = baddr_q;
    if (bias_re_d) baddr_d = bbase_q + ADDR_W'(row_q);
    wre_d     = mac_act;
    in_re_d   = mac_act;
    waddr_d   = mac_act ? wptr_q : waddr_q;
    iaddr_d   = mac_act ? col_q : iaddr_q;
    ext_d     = busy_d && (layer_q == 2'd0);
    rdb_d     = busy_d && !layer_q[0];
    wrb_d     = busy_d && layer_q[0];
    mac_en_d  = in_re_q;
    we_d      = (state_q == S_WRITE);
    oaddr_d   = we_d ? row_q : oaddr_q;
`ifdef FC_SEQ_RELU_EN
    relu_d    = we_d && (layer_q != LAST_L);
`else
    relu_d    = 1'b0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      layer_q   <= '0;
      row_q     <= '0;
      col_q     <= '0;
      wptr_q    <= '0;
      bbase_q   <= '0;
      drain_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lyr_q     <= '0;
      bias_re_q <= 1'b0;
      baddr_q   <= '0;
      wre_q     <= 1'b0;
      waddr_q   <= '0;
      in_re_q   <= 1'b0;
      iaddr_q   <= '0;
      ext_q     <= 1'b0;
      rdb_q     <= 1'b0;
      wrb_q     <= 1'b0;
      mac_en_q  <= 1'b0;
      we_q      <= 1'b0;
      oaddr_q   <= '0;
      relu_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      layer_q   <= layer_d;
      row_q     <= row_d;
      col_q     <= col_d;
      wptr_q    <= wptr_d;
      bbase_q   <= bbase_d;
      drain_q   <= drain_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      lyr_q     <= lyr_d;
      bias_re_q <= bias_re_d;
      baddr_q   <= baddr_d;
      wre_q     <= wre_d;
      waddr_q   <= waddr_d;
      in_re_q   <= in_re_d;
      iaddr_q   <= iaddr_d;
      ext_q     <= ext_d;
      rdb_q     <= rdb_d;
      wrb_q     <= wrb_d;
      mac_en_q  <= mac_en_d;
      we_q      <= we_d;
      oaddr_q   <= oaddr_d;
      relu_q    <= relu_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign layer_o       = lyr_q;
  assign bias_re_o     = bias_re_q;
  assign acc_clr_o     = bias_re_q;
  assign bias_addr_o   = baddr_q;
  assign weight_re_o   = wre_q;
  assign weight_addr_o = waddr_q;
  assign in_re_o       = in_re_q;
  assign in_addr_o     = iaddr_q;
  assign in_ext_o      = ext_q;
  assign rd_bank_o     = rdb_q;
  assign wr_bank_o     = wrb_q;
  assign mac_en_o      = mac_en_q;
  assign out_we_o      = we_q;
  assign out_addr_o    = oaddr_q;
  assign relu_en_o     = relu_q;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Bench for fc_layer_sequencer: slot-list reference model plus a scenario table.
module tb_fc_layer_sequencer;

  localparam int NL = 2;
  localparam int PL = 2;
  localparam int CW = 10;
  localparam int AW = 16;
  localparam int MAXC = 1000;

  logic          clk_i = 1'b0;
  logic          rst_i, start_i, stall_i;
  logic          busy_o, done_o, bias_re_o, weight_re_o, in_re_o, in_ext_o;
  logic          rd_bank_o, wr_bank_o, acc_clr_o, mac_en_o, out_we_o, relu_en_o;
  logic [1:0]    layer_o;
  logic [AW-1:0] bias_addr_o, weight_addr_o;
  logic [CW-1:0] in_addr_o, out_addr_o;

  always #5 clk_i = ~clk_i;

  fc_layer_sequencer #(
    .NUM_LAYERS(NL), .LEN0(4), .LEN1(3), .LEN2(2), .LEN3(0), .LEN4(0),
    .COUNT_WID(CW), .ADDR_W(AW), .PIPE_LAT(PL)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .busy_o(busy_o), .done_o(done_o), .layer_o(layer_o),
    .bias_re_o(bias_re_o), .bias_addr_o(bias_addr_o),
    .weight_re_o(weight_re_o), .weight_addr_o(weight_addr_o),
    .in_re_o(in_re_o), .in_addr_o(in_addr_o), .in_ext_o(in_ext_o),
    .rd_bank_o(rd_bank_o), .wr_bank_o(wr_bank_o), .acc_clr_o(acc_clr_o),
    .mac_en_o(mac_en_o), .out_we_o(out_we_o), .out_addr_o(out_addr_o),
    .relu_en_o(relu_en_o)
  );

  localparam logic [2:0] K_BIAS = 3'd1, K_MAC = 3'd2, K_DRAIN = 3'd3,
                         K_WRITE = 3'd4, K_NEXT = 3'd5, K_DONE = 3'd6;

  typedef struct packed {
    logic [2:0]    kind;
    logic          busy, done;
    logic [1:0]    layer;
    logic          bias_re;
    logic [AW-1:0] baddr;
    logic          wre;
    logic [AW-1:0] waddr;
    logic [CW-1:0] iaddr;
    logic          ext, rdb, wrb, mac_en, owe;
    logic [CW-1:0] oaddr;
    logic          relu;
  } exp_t;

  typedef struct {
    int stall_at;
    int stall_len;
    bit rnd;
    bit rst_drain;
    int exp_done;   // >0 exact cycle, 0 any cycle, -1 never
    int exp_wr0;
    int exp_wr1;
  } scen_t;

  int   lens [5] = '{4, 3, 2, 0, 0};
  exp_t q[$];
  int   n_chk = 0, n_fail = 0;

  function automatic exp_t blank(input int l);
    exp_t s = '0;
    s.busy  = 1'b1;
    s.layer = 2'(l);
    s.ext   = (l == 0);
    s.rdb   = ((l % 2) == 0);
    s.wrb   = ((l % 2) == 1);
    return s;
  endfunction

  // Whole inference as an ordered list of one-cycle slots
  task automatic build_model();
    exp_t s;
    int   wp = 0, boff = 0;
    q.delete();
    for (int l = 0; l < NL; l++) begin
      for (int r = 0; r < lens[l+1]; r++) begin
        s = blank(l); s.kind = K_BIAS; s.bias_re = 1'b1; s.baddr = AW'(boff + r);
        q.push_back(s);
        for (int c = 0; c < lens[l]; c++) begin
          s = blank(l); s.kind = K_MAC; s.wre = 1'b1; s.waddr = AW'(wp); s.iaddr = CW'(c);
          wp++;
          q.push_back(s);
        end
        for (int p = 0; p < PL; p++) begin
          s = blank(l); s.kind = K_DRAIN; q.push_back(s);
        end
        s = blank(l); s.kind = K_WRITE; s.owe = 1'b1; s.oaddr = CW'(r);
`ifdef FC_SEQ_RELU_EN
        s.relu = (l != NL - 1);
`endif
        q.push_back(s);
      end
      boff += lens[l+1];
      s = blank(l); s.kind = K_NEXT; q.push_back(s);
    end
    s = blank(NL - 1); s.kind = K_DONE; s.done = 1'b1; q.push_back(s);
  endtask

  task automatic chk(input exp_t x, input string nm, input int cyc);
    logic ok;
    ok = (busy_o === x.busy) && (done_o === x.done) && (layer_o === x.layer) &&
         (bias_re_o === x.bias_re) && (acc_clr_o === x.bias_re) &&
         (weight_re_o === x.wre) && (in_re_o === x.wre) &&
         (in_ext_o === x.ext) && (rd_bank_o === x.rdb) && (wr_bank_o === x.wrb) &&
         (mac_en_o === x.mac_en) && (out_we_o === x.owe) && (relu_en_o === x.relu) &&
         (!x.bias_re || bias_addr_o === x.baddr) &&
         (!x.wre || (weight_addr_o === x.waddr && in_addr_o === x.iaddr)) &&
         (!x.owe || out_addr_o === x.oaddr);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s cyc %0d: got busy=%b done=%b lyr=%0d bre=%b ba=%0d wre=%b ire=%b wa=%0d ia=%0d ext=%b rb=%b wb=%b clr=%b mac=%b we=%b oa=%0d relu=%b | want busy=%b done=%b lyr=%0d bre=%b ba=%0d wre=%b wa=%0d ia=%0d ext=%b rb=%b wb=%b mac=%b we=%b oa=%0d relu=%b",
               nm, cyc, busy_o, done_o, layer_o, bias_re_o, bias_addr_o, weight_re_o, in_re_o,
               weight_addr_o, in_addr_o, in_ext_o, rd_bank_o, wr_bank_o, acc_clr_o, mac_en_o,
               out_we_o, out_addr_o, relu_en_o,
               x.busy, x.done, x.layer, x.bias_re, x.baddr, x.wre, x.waddr, x.iaddr,
               x.ext, x.rdb, x.wrb, x.mac_en, x.owe, x.oaddr, x.relu);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // Called at a negedge; returns at a negedge with the DUT idle
  task automatic run(input scen_t sc, output int done_cyc, output int wr0, output int wr1);
    exp_t x;
    logic prev_inre = 1'b0;
    bit   st, do_rst, finished = 0;
    build_model();
    done_cyc = -1; wr0 = 0; wr1 = 0;
    start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    chk('0, "start_edge", 0);
    for (int e = 1; e < MAXC; e++) begin
      if (sc.rnd) st = ($urandom_range(0, 3) == 0);
      else        st = (e >= sc.stall_at) && (e < sc.stall_at + sc.stall_len);
      do_rst  = sc.rst_drain && q.size() > 0 && q[0].kind == K_DRAIN && q[0].layer == 2'd1;
      stall_i = st;
      rst_i   = do_rst;
      @(posedge clk_i);
      if (do_rst) begin
        x = '0;
        q.delete();
      end else begin
        if (q.size() == 0)                     x = '0;
        else if (q[0].kind == K_MAC && st) begin
          x = q[0]; x.wre = 1'b0;
        end else                               x = q.pop_front();
        x.mac_en = prev_inre;
      end
      prev_inre = x.wre;
      @(negedge clk_i);
      stall_i = 1'b0;
      rst_i   = 1'b0;
      chk(x, "cycle", e);
      if (done_o) done_cyc = e;
      if (out_we_o) begin
        if (layer_o == 2'd0) wr0++;
        else                 wr1++;
      end
      if (q.size() == 0 && !x.busy) begin
        finished = 1;
        break;
      end
    end
    if (!finished) begin
      n_chk++; n_fail++;
      $display("FAIL timeout: run did not return to idle within %0d cycles", MAXC);
    end
  endtask

  scen_t tbl [8];

  initial begin
    int dc, w0, w1;
    tbl[0] = '{stall_at: 0,  stall_len: 0, rnd: 0, rst_drain: 0, exp_done: 41, exp_wr0: 3, exp_wr1: 2};
    tbl[1] = '{stall_at: 11, stall_len: 5, rnd: 0, rst_drain: 0, exp_done: 46, exp_wr0: 3, exp_wr1: 2};
    tbl[2] = '{stall_at: 6,  stall_len: 4, rnd: 0, rst_drain: 0, exp_done: 41, exp_wr0: 3, exp_wr1: 2};
    tbl[3] = '{stall_at: 5,  stall_len: 1, rnd: 0, rst_drain: 0, exp_done: 42, exp_wr0: 3, exp_wr1: 2};
    tbl[4] = '{stall_at: 0,  stall_len: 0, rnd: 0, rst_drain: 1, exp_done: -1, exp_wr0: 3, exp_wr1: 0};
    tbl[5] = '{stall_at: 0,  stall_len: 0, rnd: 0, rst_drain: 0, exp_done: 41, exp_wr0: 3, exp_wr1: 2};
    tbl[6] = '{stall_at: 0,  stall_len: 0, rnd: 1, rst_drain: 0, exp_done: 0,  exp_wr0: 3, exp_wr1: 2};
    tbl[7] = '{stall_at: 0,  stall_len: 0, rnd: 1, rst_drain: 0, exp_done: 0,  exp_wr0: 3, exp_wr1: 2};

    rst_i = 1'b1; start_i = 1'b1; stall_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      chk('0, "reset", i);
    end
    rst_i = 1'b0; start_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    chk('0, "idle_after_reset", 0);

    for (int t = 0; t < 8; t++) begin
      run(tbl[t], dc, w0, w1);
      if (tbl[t].exp_done > 0)       chk_int($sformatf("done_cycle[%0d]", t), dc, tbl[t].exp_done);
      else if (tbl[t].exp_done == 0) chk_int($sformatf("done_seen[%0d]", t), int'(dc > 0), 1);
      else                           chk_int($sformatf("no_done[%0d]", t), dc, -1);
      chk_int($sformatf("writes_l0[%0d]", t), w0, tbl[t].exp_wr0);
      chk_int($sformatf("writes_l1[%0d]", t), w1, tbl[t].exp_wr1);
      for (int g = 0; g < 2; g++) begin
        @(posedge clk_i);
        @(negedge clk_i);
        chk('0, $sformatf("gap[%0d]", t), g);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
